table_fetcher: RTL and testbench

TABLE_FETCHER -- requirements
Module: table_fetcher

---
 rtl/table_fetcher_pkg.sv | 20 ++
 rtl/addr_stack.sv | 44 ++++
 rtl/table_fetcher.sv | 136 +++++++++++++
 tb/tb_table_fetcher.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/table_fetcher_pkg.sv
// Shared types and defaults for the descriptor-table walker.
package table_fetcher_pkg;

  localparam int DEFAULT_ENTRY_BYTES = 32;
  localparam int DEFAULT_STACK_DEPTH = 16;

  typedef struct packed {
    logic [7:0]  field_id;
    logic [4:0]  entry_type;
    logic        repeated;
    logic        nested;
    logic [63:0] offset;
    logic [63:0] nested_table_addr;
  } table_entry_t;

  function automatic logic is_terminator(input table_entry_t e);
    return e.field_id == 8'd0;
  endfunction

endpackage

// File: rtl/addr_stack.sv
// Return-address stack for nested descriptor tables; push and pop are never
// requested in the same cycle by the walker.
module addr_stack #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    sp;

  assign empty = (sp == '0);
  assign full  = (sp == PW'(DEPTH));
  assign top   = empty ? '0 : mem[IW'(sp - 1'b1)];

  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

  // Storage needs no reset; only entries below sp are ever read.
  always_ff @(posedge clk) begin
    if (!reset && push && !full) begin
      mem[IW'(sp)] <= push_data;
    end
  end

endmodule

// File: rtl/table_fetcher.sv
// Depth-first descriptor-table walker: fetches entries, forwards each one to the
// object buffer, and follows nested tables through a return-address stack.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | read outstanding at fetch pointer
// PUSH  | entry registered, waiting for buffer space
// GAP   | no-push cycle; next read is already issued here
// DONE  | one-cycle completion pulse
// ERROR | stack overflow, parked until reset
module table_fetcher
  import table_fetcher_pkg::*;
#(
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH,
  parameter int ENTRY_BYTES = DEFAULT_ENTRY_BYTES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [63:0]  root_table_addr,
  input  logic [63:0]  cpp_obj_addr,
  output logic         mem_req,
  output logic [63:0]  mem_addr,
  input  logic         mem_resp_valid,
  input  table_entry_t mem_resp_data,
  input  logic         buf_full,
  output table_entry_t new_entry,
  output logic         valid_in,
  output logic [63:0]  new_cpp_base_addr,
  output logic         new_cpp_base_addr_valid,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_PUSH  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  logic [2:0]  state;
  logic [63:0] fptr;
  logic [63:0] ret_addr;
  logic [63:0] stk_top;
  logic        stk_empty;
  logic        stk_full;
  logic        stk_push;
  logic        stk_pop;
  logic        push_now;

  assign push_now = (state == S_PUSH) && !buf_full;
  assign ret_addr = fptr + 64'(ENTRY_BYTES);
  assign stk_push = push_now && new_entry.nested && !stk_full;
  assign stk_pop  = push_now && !new_entry.nested && is_terminator(new_entry) && !stk_empty;

  assign valid_in = push_now;
  assign mem_req  = (state == S_REQ) || (state == S_GAP);
  assign mem_addr = mem_req ? fptr : '0;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  addr_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (64)
  ) u_addr_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (ret_addr),
    .top       (stk_top),
    .empty     (stk_empty),
    .full      (stk_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= S_IDLE;
      fptr                    <= '0;
      new_entry               <= '0;
      new_cpp_base_addr       <= '0;
      new_cpp_base_addr_valid <= 1'b0;
      error                   <= 1'b0;
    end else begin
      new_cpp_base_addr_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            fptr                    <= root_table_addr;
            new_cpp_base_addr       <= cpp_obj_addr;
            new_cpp_base_addr_valid <= 1'b1;
            state                   <= S_REQ;
          end
        end
        S_REQ, S_GAP: begin
          if (mem_resp_valid) begin
            new_entry <= mem_resp_data;
            state     <= S_PUSH;
          end else begin
            state <= S_REQ;
          end
        end
        S_PUSH: begin
          // Next address is resolved here so GAP can already carry the read.
          if (!buf_full) begin
            if (new_entry.nested) begin
              if (stk_full) begin
                error <= 1'b1;
                state <= S_ERROR;
              end else begin
                fptr  <= new_entry.nested_table_addr;
                state <= S_GAP;
              end
            end else if (is_terminator(new_entry)) begin
              if (!stk_empty) begin
                fptr  <= stk_top;
                state <= S_GAP;
              end else begin
                state <= S_DONE;
              end
            end else begin
              fptr  <= ret_addr;
              state <= S_GAP;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERROR: state <= S_ERROR;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_table_fetcher.sv
// Bench for table_fetcher: a scenario table checked against a depth-first walk
// model, plus hand-written buffer-stall and mid-read reset sequences.
module tb_table_fetcher;
  import table_fetcher_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [63:0]  root_table_addr;
  logic [63:0]  cpp_obj_addr;
  logic         mem_req;
  logic [63:0]  mem_addr;
  logic         mem_resp_valid;
  table_entry_t mem_resp_data;
  logic         buf_full;
  table_entry_t new_entry;
  logic         valid_in;
  logic [63:0]  new_cpp_base_addr;
  logic         new_cpp_base_addr_valid;
  logic         busy;
  logic         done;
  logic         error;

  table_fetcher dut (
    .clk                     (clk),
    .reset                   (reset),
    .start                   (start),
    .root_table_addr         (root_table_addr),
    .cpp_obj_addr            (cpp_obj_addr),
    .mem_req                 (mem_req),
    .mem_addr                (mem_addr),
    .mem_resp_valid          (mem_resp_valid),
    .mem_resp_data           (mem_resp_data),
    .buf_full                (buf_full),
    .new_entry               (new_entry),
    .valid_in                (valid_in),
    .new_cpp_base_addr       (new_cpp_base_addr),
    .new_cpp_base_addr_valid (new_cpp_base_addr_valid),
    .busy                    (busy),
    .done                    (done),
    .error                   (error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory and buffer environment
  table_entry_t mem_tbl [logic [63:0]];
  bit mem_rand = 0, mem_mute = 0, force_resp = 0, bf_rand = 0, bf_force = 0;

  function automatic table_entry_t lookup(input logic [63:0] a);
    if (mem_tbl.exists(a)) return mem_tbl[a];
    return '0;
  endfunction

  always @(negedge clk) begin
    bit resp_ok;
    resp_ok        = !mem_rand || ($urandom_range(0, 2) == 0);
    mem_resp_valid = (mem_req && resp_ok && !mem_mute) || force_resp;
    mem_resp_data  = lookup(mem_addr);
    buf_full       = bf_rand ? ($urandom_range(0, 2) == 0) : bf_force;
  end

  // monitor
  table_entry_t push_q[$];
  int           pcyc_q[$];
  logic [63:0]  addr_q[$];
  int done_cnt = 0, post_err_act = 0;
  bit err_seen = 0;

  always @(negedge clk) begin
    #1;
    if (valid_in) begin
      push_q.push_back(new_entry);
      pcyc_q.push_back(cyc);
    end
    if (mem_req && mem_resp_valid) addr_q.push_back(mem_addr);
    if (done) done_cnt++;
    if (err_seen && (mem_req || valid_in)) post_err_act++;
    if (error) err_seen = 1;
  end

  // reference walk
  table_entry_t exp_ent[$];
  logic [63:0]  exp_addr[$];
  bit           exp_err;

  task automatic ref_walk(input logic [63:0] root);
    logic [63:0] stk[$];
    logic [63:0] p = root;
    table_entry_t e;
    exp_ent.delete(); exp_addr.delete(); exp_err = 0;
    for (int k = 0; k < 5000; k++) begin
      e = lookup(p);
      exp_addr.push_back(p);
      exp_ent.push_back(e);
      if (e.nested) begin
        if (stk.size() == DEFAULT_STACK_DEPTH) begin exp_err = 1; break; end
        stk.push_back(p + 64'd32);
        p = e.nested_table_addr;
      end else if (e.field_id == 0) begin
        if (stk.size() == 0) break;
        p = stk.pop_back();
      end else begin
        p = p + 64'd32;
      end
    end
  endtask

  function automatic table_entry_t mk(input int fid, input bit nst, input logic [63:0] na);
    table_entry_t e;
    e.field_id = 8'(fid);
    e.entry_type = 5'($urandom);
    e.repeated = 1'($urandom);
    e.nested = nst;
    e.offset = {$urandom, $urandom};
    e.nested_table_addr = na;
    return e;
  endfunction

  task automatic build_flat(input logic [63:0] r);
    mem_tbl[r]          = mk(1, 0, 64'h0);
    mem_tbl[r + 64'd32] = mk(2, 0, 64'h0);
    mem_tbl[r + 64'd64] = mk(0, 0, 64'h0);
  endtask

  task automatic build_nested();
    mem_tbl[64'h1000] = mk(1, 1, 64'h2000);
    mem_tbl[64'h2000] = mk(5, 0, 64'h0);
    mem_tbl[64'h2020] = mk(0, 0, 64'h0);
    mem_tbl[64'h1020] = mk(2, 0, 64'h0);
    mem_tbl[64'h1040] = mk(0, 0, 64'h0);
  endtask

  task automatic build_chain(input logic [63:0] r);
    for (int k = 0; k < 18; k++) begin
      mem_tbl[r + 64'(k) * 64'h10000]          = mk(k + 1, 1, r + 64'(k + 1) * 64'h10000);
      mem_tbl[r + 64'(k) * 64'h10000 + 64'd32] = mk(0, 0, 64'h0);
    end
  endtask

  task automatic build_random(input logic [63:0] r);
    logic [63:0] base_q[$];
    int          dep_q[$];
    logic [63:0] nb = r + 64'h1000;
    logic [63:0] b;
    int d, n;
    bit nst;
    base_q.push_back(r); dep_q.push_back(0);
    while (base_q.size() > 0) begin
      b = base_q.pop_front(); d = dep_q.pop_front();
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        nst = (d < 3) && ($urandom_range(0, 2) == 0);
        if (nst) begin
          mem_tbl[b + 64'(i * 32)] = mk($urandom_range(1, 255), 1, nb);
          base_q.push_back(nb); dep_q.push_back(d + 1);
          nb = nb + 64'h1000;
        end else begin
          mem_tbl[b + 64'(i * 32)] = mk($urandom_range(1, 255), 0, {$urandom, $urandom});
        end
      end
      mem_tbl[b + 64'(n * 32)] = mk(0, 0, {$urandom, $urandom});
    end
  endtask

  // helpers
  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #2; end
  endtask

  task automatic chk(input string nm, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic clear_mon();
    push_q.delete(); pcyc_q.delete(); addr_q.delete();
    done_cnt = 0; post_err_act = 0; err_seen = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0;
    step(2);
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, " ctl"}, 192'({mem_req, mem_addr, valid_in, new_cpp_base_addr,
                            new_cpp_base_addr_valid, busy, done, error}), 192'(0));
    chk({nm, " new_entry"}, 192'(new_entry), 192'(0));
  endtask

  task automatic pulse_start(input logic [63:0] r, input logic [63:0] c);
    root_table_addr = r; cpp_obj_addr = c; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    int n = 0;
    while (done_cnt == 0 && !err_seen && n < 3000) begin step(1); n++; end
    chk({nm, " finished"}, 192'(n < 3000), 192'(1));
    step(6);
  endtask

  task automatic chk_seq(input string nm);
    bit gap_ok = 1;
    chk({nm, " push_count"}, 192'(push_q.size()), 192'(exp_ent.size()));
    for (int i = 0; i < exp_ent.size() && i < push_q.size(); i++)
      chk($sformatf("%s push%0d", nm, i), 192'(push_q[i]), 192'(exp_ent[i]));
    chk({nm, " fetch_count"}, 192'(addr_q.size()), 192'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < addr_q.size(); i++)
      chk($sformatf("%s fetch%0d", nm, i), 192'(addr_q[i]), 192'(exp_addr[i]));
    for (int i = 1; i < pcyc_q.size(); i++)
      if (pcyc_q[i] - pcyc_q[i-1] < 2) gap_ok = 0;
    chk({nm, " min_spacing"}, 192'(gap_ok), 192'(1));
    chk({nm, " error"}, 192'(error), 192'(exp_err));
    chk({nm, " done_pulses"}, 192'(done_cnt), 192'(!exp_err));
    chk({nm, " busy_end"}, 192'(busy), 192'(exp_err));
    chk({nm, " post_error_activity"}, 192'(post_err_act), 192'(0));
  endtask

  typedef struct {
    int          kind;
    logic [63:0] root;
    logic [63:0] cpp;
    bit          rand_lat;
    bit          rand_bf;
    int          exp_pushes;
    bit          exp_error;
  } vec_t;
  vec_t vec[10];

  initial begin
    table_entry_t held;
    int bad_valid, bad_hold;
    logic [63:0] nest_addr[5];
    string nm;

    vec[0] = '{0, 64'h1000, 64'h100, 0, 0, 3, 0};
    vec[1] = '{1, 64'h1000, 64'h2468, 0, 0, 5, 0};
    vec[2] = '{2, 64'h10000, 64'h55, 0, 0, 17, 1};
    vec[3] = '{1, 64'h1000, 64'habc, 1, 1, 5, 0};
    vec[4] = '{0, 64'hffff_ffff_ffff_ffe0, 64'h9, 0, 1, 3, 0};
    vec[5] = '{3, 64'h40000, 64'h1111, 1, 0, -1, 0};
    vec[6] = '{3, 64'h40000, 64'h2222, 0, 1, -1, 0};
    vec[7] = '{3, 64'h40000, 64'h3333, 1, 1, -1, 0};
    vec[8] = '{3, 64'h40000, 64'h4444, 0, 0, -1, 0};
    vec[9] = '{3, 64'h40000, 64'h5555, 1, 1, -1, 0};
    nest_addr[0] = 64'h1000; nest_addr[1] = 64'h2000; nest_addr[2] = 64'h2020;
    nest_addr[3] = 64'h1020; nest_addr[4] = 64'h1040;

    reset = 1'b1; start = 1'b0; root_table_addr = '0; cpp_obj_addr = '0;
    step(2);
    chk_zero_outputs("reset_state");
    reset = 1'b0;

    for (int s = 0; s < 10; s++) begin
      nm = $sformatf("vec%0d", s);
      do_reset();
      mem_tbl.delete();
      case (vec[s].kind)
        0: build_flat(vec[s].root);
        1: build_nested();
        2: build_chain(vec[s].root);
        default: build_random(vec[s].root);
      endcase
      ref_walk(vec[s].root);
      mem_rand = vec[s].rand_lat; bf_rand = vec[s].rand_bf; bf_force = 0;
      pulse_start(vec[s].root, vec[s].cpp);
      chk({nm, " cpp_valid"}, 192'(new_cpp_base_addr_valid), 192'(1));
      chk({nm, " cpp_addr"}, 192'(new_cpp_base_addr), 192'(vec[s].cpp));
      chk({nm, " busy"}, 192'(busy), 192'(1));
      step(1);
      chk({nm, " cpp_valid_one_cycle"}, 192'(new_cpp_base_addr_valid), 192'(0));
      wait_end(nm);
      chk_seq(nm);
      if (vec[s].exp_pushes >= 0)
        chk({nm, " push_total"}, 192'(push_q.size()), 192'(vec[s].exp_pushes));
      if (vec[s].exp_pushes >= 0)
        chk({nm, " error_expected"}, 192'(error), 192'(vec[s].exp_error));
      if (vec[s].kind == 0 && !vec[s].rand_lat && !vec[s].rand_bf && pcyc_q.size() == 3) begin
        chk({nm, " spacing01"}, 192'(pcyc_q[1] - pcyc_q[0]), 192'(2));
        chk({nm, " spacing12"}, 192'(pcyc_q[2] - pcyc_q[1]), 192'(2));
      end
      if (vec[s].kind == 1 && addr_q.size() == 5)
        for (int i = 0; i < 5; i++)
          chk($sformatf("%s nest_addr%0d", nm, i), 192'(addr_q[i]), 192'(nest_addr[i]));
    end
    mem_rand = 0; bf_rand = 0;

    // buf_full held for 10 cycles in PUSH; a start during the walk is ignored
    do_reset();
    mem_tbl.delete();
    build_flat(64'h1000);
    ref_walk(64'h1000);
    bf_force = 1;
    pulse_start(64'h1000, 64'h100);
    step(1);
    held = new_entry;
    chk("stall entry_loaded", 192'(held), 192'(exp_ent[0]));
    bad_valid = 0; bad_hold = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin root_table_addr = 64'h9000; cpp_obj_addr = 64'h77; start = 1'b1; end
      if (i == 4) start = 1'b0;
      step(1);
      if (valid_in) bad_valid++;
      if (new_entry !== held) bad_hold++;
    end
    chk("stall valid_in_low", 192'(bad_valid), 192'(0));
    chk("stall entry_stable", 192'(bad_hold), 192'(0));
    chk("stall no_push_yet", 192'(push_q.size()), 192'(0));
    bf_force = 0;
    step(1);
    chk("stall release_pulse", 192'(valid_in), 192'(1));
    step(1);
    chk("stall release_single", 192'(valid_in), 192'(0));
    wait_end("stall");
    chk_seq("stall");
    chk("stall cpp_unchanged", 192'(new_cpp_base_addr), 192'(64'h100));

    // reset during an outstanding read, then a late response in IDLE
    do_reset();
    mem_tbl.delete();
    build_flat(64'h1000);
    mem_mute = 1;
    pulse_start(64'h1000, 64'h77);
    step(2);
    chk("midreset mem_req", 192'(mem_req), 192'(1));
    chk("midreset mem_addr", 192'(mem_addr), 192'(64'h1000));
    reset = 1'b1;
    step(1);
    chk_zero_outputs("midreset");
    reset = 1'b0; mem_mute = 0;
    clear_mon();
    force_resp = 1;
    step(1);
    force_resp = 0;
    step(4);
    chk("late_resp no_push", 192'(push_q.size()), 192'(0));
    chk("late_resp idle", 192'({busy, mem_req, valid_in, done}), 192'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
